mux_sel_sequencer: RTL and testbench

Upstream control stage for the N-to-1 bit multiplexer. It accepts an N-bit word over a valid/ready load handshake, holds it on the mux data inputs, and steps the mux select through every bit position, one per accepted output beat. The mux output is forwarded to a downstream valid/ready serial bit stream with an end-of-word marker. The result is a word-to-bitstream serializer built around the existing mux.

---
 rtl/mux_sel_sequencer_if.sv | 29 ++
 rtl/mux_sel_sequencer.sv | 89 ++++++++
 tb/tb_mux_sel_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_if.sv
// Bundle of the load handshake, mux drive/return and serial bit stream
// for the mux select sequencer.
interface mux_sel_sequencer_if #(
  parameter int N = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]     load_data;
  logic             load_valid;
  logic             load_ready;
  logic [N-1:0]     mux_data_in;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_last;
  logic             busy;

  modport master (
    input  load_data, load_valid, mux_out, bit_ready,
    output load_ready, mux_data_in, mux_sel, bit_out, bit_valid, bit_last, busy
  );

  modport slave (
    output load_data, load_valid, mux_out, bit_ready,
    input  load_ready, mux_data_in, mux_sel, bit_out, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Word-to-bitstream serializer: holds a loaded word on the mux inputs and
// walks the mux select across every bit, one position per accepted beat.
module mux_sel_sequencer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_sequencer_if.master  bus
);
  localparam int SEL_W = $clog2(N);
  localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(N - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     word_q, word_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  logic shifting;
  logic at_last;
  logic beat_fire;
  logic load_ready;
  logic load_fire;

  assign shifting   = (state_q == SHIFT);
  assign at_last    = shifting && (idx_q == LAST_IDX);
  assign beat_fire  = shifting && bus.bit_ready;
  // A new word may be taken on the final beat so consecutive words abut.
  assign load_ready = !rst && (!shifting || (bus.bit_ready && at_last));
  assign load_fire  = bus.load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          word_d  = bus.load_data;
          idx_d   = START_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_fire) begin
          if (at_last) begin
            if (load_fire) begin
              word_d = bus.load_data;
              idx_d  = START_IDX;
            end else begin
              state_d = IDLE;
            end
          end else if (MSB_FIRST) begin
            idx_d = idx_q - SEL_W'(1);
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-word.
  assign bus.load_ready  = load_ready;
  assign bus.bit_valid   = !rst && shifting;
  assign bus.busy        = !rst && shifting;
  assign bus.bit_last    = !rst && at_last;
  assign bus.mux_sel     = rst ? '0 : idx_q;
  assign bus.mux_data_in = rst ? '0 : word_q;
  assign bus.bit_out     = bus.mux_out;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer: an LSB-first and an MSB-first
// instance, each closed through a behavioural N-to-1 mux.
module tb_mux_sel_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.N(8)) bl ();
  mux_sel_sequencer_if #(.N(8)) bm ();

  mux_sel_sequencer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl.master));
  mux_sel_sequencer #(.N(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm.master));

  assign bl.mux_out = bl.mux_data_in[bl.mux_sel];
  assign bm.mux_out = bm.mux_data_in[bm.mux_sel];

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.sel  = msb ? 3'(7 - i) : 3'(i);
      e.b    = w[e.sel];
      e.last = (i == 7);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bl.load_valid = 1'b1; bl.load_data = 8'hFF; bl.bit_ready = 1'b1;
    bm.load_valid = 1'b0; bm.load_data = 8'h00; bm.bit_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({bl.load_ready, bl.bit_valid, bl.bit_last, bl.busy, bl.mux_sel, bl.mux_data_in} !== 15'd0) begin
        n_bad++;
        $display("FAIL reset_outputs got rdy=%b vld=%b last=%b busy=%b sel=%0d din=%h want all 0",
                 bl.load_ready, bl.bit_valid, bl.bit_last, bl.busy, bl.mux_sel, bl.mux_data_in);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bl.load_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bl.load_ready, bm.load_ready, bl.bit_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_release got rdy_l=%b rdy_m=%b vld=%b want 1 1 0",
               bl.load_ready, bm.load_ready, bl.bit_valid);
    end
  endtask

  task automatic test_lsb_word();
    exp_t e;
    int beats = 0;
    @(posedge clk); #1;
    bl.load_data = 8'b10101010; bl.load_valid = 1'b1; bl.bit_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bl.load_valid && bl.load_ready) push_word(bl.load_data, 1'b0);
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if (bl.bit_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL lsb_consecutive cycle=%0d got vld=%b want 1", c, bl.bit_valid);
        end
      end
      if (bl.bit_valid && bl.bit_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL lsb_extra_beat got beat sel=%0d want none", bl.mux_sel);
        end else begin
          e = sb.pop_front();
          beats++;
          if ({bl.bit_out, bl.mux_sel, bl.bit_last} !== e) begin
            n_bad++;
            $display("FAIL lsb_beat got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                     bl.bit_out, bl.mux_sel, bl.bit_last, e.b, e.sel, e.last);
          end
        end
      end
      @(posedge clk); #1;
      bl.load_valid = 1'b0;
    end
    n_cmp++;
    if (beats != 8 || sb.size() != 0 || bl.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL lsb_done got beats=%0d pending=%0d busy=%b want 8 0 0", beats, sb.size(), bl.busy);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int beats = 0;
    int stall = 0;
    @(posedge clk); #1;
    bl.load_data = 8'b11110000; bl.load_valid = 1'b1; bl.bit_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bl.load_valid && bl.load_ready) push_word(bl.load_data, 1'b0);
      if (!bl.bit_ready) begin
        n_cmp++;
        if ({bl.bit_valid, bl.mux_sel, bl.bit_out, bl.bit_last} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL bp_hold got vld=%b sel=%0d bit=%b last=%b want 1 2 0 0",
                   bl.bit_valid, bl.mux_sel, bl.bit_out, bl.bit_last);
        end
      end
      if (bl.bit_valid && bl.bit_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra_beat got beat sel=%0d want none", bl.mux_sel);
        end else begin
          e = sb.pop_front();
          beats++;
          if ({bl.bit_out, bl.mux_sel, bl.bit_last} !== e) begin
            n_bad++;
            $display("FAIL bp_beat got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                     bl.bit_out, bl.mux_sel, bl.bit_last, e.b, e.sel, e.last);
          end
        end
      end
      @(posedge clk); #1;
      bl.load_valid = 1'b0;
      bl.bit_ready  = !(beats == 2 && stall < 4);
      if (!bl.bit_ready) stall++;
    end
    bl.bit_ready = 1'b1;
    n_cmp++;
    if (beats != 8 || sb.size() != 0 || bl.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_done got beats=%0d pending=%0d busy=%b want 8 0 0", beats, sb.size(), bl.busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int beats = 0;
    int nacc = 0;
    @(posedge clk); #1;
    bl.load_data = 8'h00; bl.load_valid = 1'b1; bl.bit_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bl.load_valid && bl.load_ready) begin
        push_word(bl.load_data, 1'b0);
        nacc++;
        if (nacc == 2) begin
          n_cmp++;
          if (bl.bit_last !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_on_last got last=%b want 1", bl.bit_last);
          end
        end
      end
      if (c >= 1 && c <= 16) begin
        n_cmp++;
        if (bl.bit_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_no_bubble cycle=%0d got vld=%b want 1", c, bl.bit_valid);
        end
      end
      if (bl.bit_valid && bl.bit_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra_beat got beat sel=%0d want none", bl.mux_sel);
        end else begin
          e = sb.pop_front();
          beats++;
          if ({bl.bit_out, bl.mux_sel, bl.bit_last} !== e) begin
            n_bad++;
            $display("FAIL b2b_beat n=%0d got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                     beats, bl.bit_out, bl.mux_sel, bl.bit_last, e.b, e.sel, e.last);
          end
        end
      end
      @(posedge clk); #1;
      if (nacc == 1) bl.load_data = 8'hFF;
      if (nacc >= 2) bl.load_valid = 1'b0;
    end
    n_cmp++;
    if (beats != 16 || nacc != 2 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_done got beats=%0d loads=%0d pending=%0d want 16 2 0", beats, nacc, sb.size());
    end
  endtask

  task automatic test_msb_word();
    exp_t e;
    int beats = 0;
    @(posedge clk); #1;
    bm.load_data = 8'b11110000; bm.load_valid = 1'b1; bm.bit_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bm.load_valid && bm.load_ready) push_word(bm.load_data, 1'b1);
      if (bm.bit_valid && bm.bit_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL msb_extra_beat got beat sel=%0d want none", bm.mux_sel);
        end else begin
          e = sb.pop_front();
          beats++;
          if ({bm.bit_out, bm.mux_sel, bm.bit_last} !== e) begin
            n_bad++;
            $display("FAIL msb_beat got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                     bm.bit_out, bm.mux_sel, bm.bit_last, e.b, e.sel, e.last);
          end
        end
      end
      @(posedge clk); #1;
      bm.load_valid = 1'b0;
    end
    n_cmp++;
    if (beats != 8 || sb.size() != 0 || bm.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL msb_done got beats=%0d pending=%0d busy=%b want 8 0 0", beats, sb.size(), bm.busy);
    end
  endtask

  task automatic test_reset_mid_word();
    exp_t e;
    int beats = 0;
    @(posedge clk); #1;
    bl.load_data = 8'b10101010; bl.load_valid = 1'b1; bl.bit_ready = 1'b1;
    for (int c = 0; c < 10 && beats < 3; c++) begin
      @(negedge clk);
      if (bl.load_valid && bl.load_ready) push_word(bl.load_data, 1'b0);
      if (bl.bit_valid && bl.bit_ready && sb.size() != 0) begin
        e = sb.pop_front();
        beats++;
        n_cmp++;
        if ({bl.bit_out, bl.mux_sel, bl.bit_last} !== e) begin
          n_bad++;
          $display("FAIL rmid_pre_beat got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                   bl.bit_out, bl.mux_sel, bl.bit_last, e.b, e.sel, e.last);
        end
      end
      @(posedge clk); #1;
      bl.load_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bl.bit_valid, bl.load_ready, bl.busy, bl.mux_sel} !== 6'd0) begin
      n_bad++;
      $display("FAIL rmid_during got vld=%b rdy=%b busy=%b sel=%0d want 0 0 0 0",
               bl.bit_valid, bl.load_ready, bl.busy, bl.mux_sel);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bl.bit_valid, bl.busy, bl.mux_sel, bl.load_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL rmid_after got vld=%b busy=%b sel=%0d rdy=%b want 0 0 0 1",
               bl.bit_valid, bl.busy, bl.mux_sel, bl.load_ready);
    end
    sb.delete();
    beats = 0;
    @(posedge clk); #1;
    bl.load_data = 8'b00000001; bl.load_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bl.load_valid && bl.load_ready) push_word(bl.load_data, 1'b0);
      if (bl.bit_valid && bl.bit_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rmid_extra_beat got beat sel=%0d want none", bl.mux_sel);
        end else begin
          e = sb.pop_front();
          beats++;
          if ({bl.bit_out, bl.mux_sel, bl.bit_last} !== e) begin
            n_bad++;
            $display("FAIL rmid_beat got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                     bl.bit_out, bl.mux_sel, bl.bit_last, e.b, e.sel, e.last);
          end
        end
      end
      @(posedge clk); #1;
      bl.load_valid = 1'b0;
    end
    n_cmp++;
    if (beats != 8 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL rmid_done got beats=%0d pending=%0d want 8 0", beats, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_lsb_word();
    test_backpressure();
    test_back_to_back();
    test_msb_word();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
